wmst_tile_sched: RTL and testbench

- Row-by-row store scheduler for the Avalon write-master tile path.
- Takes one 2-D output-tile descriptor (base, rows, row length, row stride) and issues one store transaction per row to the write-master tile logic (store_start / param_waddr / param_iolen / store_done).
- Waits for each row's store_done before issuing the next row, then reports completion of the whole tile.

---
 rtl/wmst_tile_sched_pkg.sv | 22 ++
 rtl/wmst_sched_gap_cnt.sv | 29 ++
 rtl/wmst_tile_sched.sv | 156 +++++++++++++++
 tb/tb_wmst_tile_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wmst_tile_sched_pkg.sv
// Shared state encoding and defaults for the wmst/rmst row schedulers.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package wmst_tile_sched_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_GAP   = 3'd3;
    localparam logic [ST_W-1:0] ST_FIN   = 3'd4;

    localparam int DEF_ISSUE_GAP = 2;
    localparam int GAP_CW        = 8;

    // States in which a tile is in progress and busy is reported.
    function automatic logic st_active(input logic [ST_W-1:0] st);
        return (st == ST_ISSUE) || (st == ST_WAIT) || (st == ST_GAP);
    endfunction

endpackage

// File: rtl/wmst_sched_gap_cnt.sv
// Loadable down-counter with zero flag, used to space row issues.
// Latency: load/decrement take effect on the next clock.
// Backpressure: none; decrement stops at zero.
module wmst_sched_gap_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wmst_tile_sched.sv
// Row-by-row store scheduler for a 2-D output tile; optional perf counters under WMST_SCHED_PERF_EN.
// Latency: store_start one cycle after cfg_start; next row ISSUE_GAP+1 cycles after store_done.
// Backpressure: one row in flight; the next row waits for store_done, cfg_start ignored while busy.
module wmst_tile_sched
    import wmst_tile_sched_pkg::*;
#(
    parameter int AW        = 12,
    parameter int XAW       = 32,
    parameter int RW        = 8,
    parameter int ISSUE_GAP = DEF_ISSUE_GAP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic [XAW-1:0] cfg_base,
    input  logic [RW-1:0]  cfg_rows,
    input  logic [AW-1:0]  cfg_row_len,
    input  logic [XAW-1:0] cfg_row_stride,
    input  logic           cfg_abort,
    output logic           store_start,
    output logic [XAW-1:0] param_waddr,
    output logic [AW-1:0]  param_iolen,
    input  logic           store_done,
    output logic           busy,
    output logic           sched_done,
    output logic [RW-1:0]  row_idx
`ifdef WMST_SCHED_PERF_EN
    ,
    output logic [31:0]    perf_cycles,
    output logic [31:0]    perf_stall
`endif
);

    localparam logic [GAP_CW-1:0] GAP_LOAD = (ISSUE_GAP > 0) ? GAP_CW'(ISSUE_GAP - 1) : '0;

    logic [ST_W-1:0] state, state_nxt;
    logic [RW-1:0]   rows_q;
    logic [XAW-1:0]  stride_q;
    logic            skip_q;

    logic            accept, degen, last_row, done_ev, row_adv;
    logic            gap_load, gap_zero;
    logic [GAP_CW-1:0] gap_val;

    assign accept   = cfg_start && (((state == ST_IDLE) && !cfg_abort) || (state == ST_FIN));
    assign degen    = (cfg_rows == '0) || (cfg_row_len == '0);
    assign last_row = (row_idx == rows_q - RW'(1));
    assign done_ev  = (state == ST_WAIT) && store_done && !cfg_abort;
    assign row_adv  = done_ev && !last_row;

    // An empty descriptor passes through one GAP cycle so sched_done lands two cycles after start.
    always_comb begin
        state_nxt = state;
        gap_load  = 1'b0;
        gap_val   = '0;
        case (state)
            ST_IDLE, ST_FIN: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (degen) begin
                        state_nxt = ST_GAP;
                        gap_load  = 1'b1;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (store_done) begin
                    if (last_row) begin
                        state_nxt = ST_FIN;
                    end else if (ISSUE_GAP == 0) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = ST_GAP;
                        gap_load  = 1'b1;
                        gap_val   = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    state_nxt = skip_q ? ST_FIN : ST_ISSUE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (st_active(state) && cfg_abort) begin
            state_nxt = ST_IDLE;
        end
    end

    wmst_sched_gap_cnt #(
        .W (GAP_CW)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_val),
        .dec      (state == ST_GAP),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            store_start <= 1'b0;
            sched_done  <= 1'b0;
            busy        <= 1'b0;
            param_waddr <= '0;
            param_iolen <= '0;
            row_idx     <= '0;
            rows_q      <= '0;
            stride_q    <= '0;
            skip_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            store_start <= (state_nxt == ST_ISSUE);
            sched_done  <= (state_nxt == ST_FIN);
            busy        <= st_active(state_nxt);
            if (accept) begin
                param_waddr <= cfg_base;
                param_iolen <= cfg_row_len;
                rows_q      <= cfg_rows;
                stride_q    <= cfg_row_stride;
                row_idx     <= '0;
                skip_q      <= degen;
            end else if (row_adv) begin
                // Wraps modulo 2^XAW by design.
                param_waddr <= param_waddr + stride_q;
                row_idx     <= row_idx + RW'(1);
            end
        end
    end

`ifdef WMST_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if ((state == ST_WAIT) && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wmst_tile_sched.sv
// Directed bench for wmst_tile_sched with default parameters (ISSUE_GAP=2).
// Inputs driven and outputs sampled on the falling edge.
module tb_wmst_tile_sched;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [31:0] cfg_base;
    logic [7:0]  cfg_rows;
    logic [11:0] cfg_row_len;
    logic [31:0] cfg_row_stride;
    logic        cfg_abort;
    logic        store_start;
    logic [31:0] param_waddr;
    logic [11:0] param_iolen;
    logic        store_done;
    logic        busy;
    logic        sched_done;
    logic [7:0]  row_idx;
`ifdef WMST_SCHED_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stall;
`endif

    wmst_tile_sched dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_base       (cfg_base),
        .cfg_rows       (cfg_rows),
        .cfg_row_len    (cfg_row_len),
        .cfg_row_stride (cfg_row_stride),
        .cfg_abort      (cfg_abort),
        .store_start    (store_start),
        .param_waddr    (param_waddr),
        .param_iolen    (param_iolen),
        .store_done     (store_done),
        .busy           (busy),
        .sched_done     (sched_done),
        .row_idx        (row_idx)
`ifdef WMST_SCHED_PERF_EN
        ,
        .perf_cycles    (perf_cycles),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int          ss_cyc[$];
    logic [31:0] ss_addr[$];
    logic [11:0] ss_len[$];
    int          sd_cyc[$];
    int          resp_cnt = -1;
    int          resp_lat = 10;
    bit          auto_en  = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: clear pulses, log outputs, and answer each store_start with store_done resp_lat cycles later.
    task automatic tick();
        @(negedge clk);
        cfg_start  = 1'b0;
        cfg_abort  = 1'b0;
        rst        = 1'b0;
        store_done = 1'b0;
        if (store_start) begin
            ss_cyc.push_back(cyc);
            ss_addr.push_back(param_waddr);
            ss_len.push_back(param_iolen);
        end
        if (sched_done) sd_cyc.push_back(cyc);
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                store_done = 1'b1;
                resp_cnt   = -1;
            end
        end
        if (store_start && auto_en) resp_cnt = resp_lat;
    endtask

    task automatic clear_logs();
        ss_cyc.delete();
        ss_addr.delete();
        ss_len.delete();
        sd_cyc.delete();
        resp_cnt = -1;
    endtask

    task automatic start(input logic [31:0] b, input logic [7:0] r,
                         input logic [11:0] l, input logic [31:0] s);
        cfg_base       = b;
        cfg_rows       = r;
        cfg_row_len    = l;
        cfg_row_stride = s;
        cfg_start      = 1'b1;
    endtask

    int n;

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; store_done = 1'b0;
        cfg_base = '0; cfg_rows = '0; cfg_row_len = '0; cfg_row_stride = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_store_start", store_start, 0);
        chk("rst_sched_done", sched_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_waddr", param_waddr, 0);
        chk("rst_iolen", param_iolen, 0);
        chk("rst_row_idx", row_idx, 0);

        // Spurious store_done in IDLE
        store_done = 1'b1;
        tick();
        chk("idle_done_row_idx", row_idx, 0);
        chk("idle_done_busy", busy, 0);

        // Nominal tile
        clear_logs();
        tick();
        n = cyc;
        start(32'h1000, 8'd3, 12'd16, 32'h100);
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 1) chk("nom_busy_on", busy, 1);
            if (k == 5) cfg_base = 32'hDEAD_0000;
            if (k == 12) store_done = 1'b1;
            if (k == 13) chk("gap_done_row_idx", row_idx, 1);
            if (k == 39) chk("nom_busy_off", busy, 0);
        end
        chk("nom_ss_count", ss_cyc.size(), 3);
        if (ss_cyc.size() == 3) begin
            chk("nom_ss0_cyc", ss_cyc[0] - n, 1);
            chk("nom_ss1_cyc", ss_cyc[1] - n, 14);
            chk("nom_ss2_cyc", ss_cyc[2] - n, 27);
            chk("nom_addr0", ss_addr[0], 32'h1000);
            chk("nom_addr1", ss_addr[1], 32'h1100);
            chk("nom_addr2", ss_addr[2], 32'h1200);
            chk("nom_len0", ss_len[0], 16);
            chk("nom_len2", ss_len[2], 16);
        end
        chk("nom_sd_count", sd_cyc.size(), 1);
        if (sd_cyc.size() == 1) chk("nom_sd_cyc", sd_cyc[0] - n, 38);

        // Degenerate: rows=0 then len=0
        for (int t = 0; t < 2; t++) begin
            clear_logs();
            tick();
            n = cyc;
            if (t == 0) start(32'h2000, 8'd0, 12'd16, 32'h10);
            else        start(32'h2000, 8'd2, 12'd0, 32'h10);
            repeat (6) tick();
            chk(t == 0 ? "rows0_ss_count" : "len0_ss_count", ss_cyc.size(), 0);
            chk(t == 0 ? "rows0_sd_count" : "len0_sd_count", sd_cyc.size(), 1);
            if (sd_cyc.size() == 1)
                chk(t == 0 ? "rows0_sd_cyc" : "len0_sd_cyc", sd_cyc[0] - n, 2);
        end

        // Address wrap
        clear_logs();
        tick();
        start(32'hFFFF_FF80, 8'd2, 12'd4, 32'h80);
        repeat (35) tick();
        chk("wrap_ss_count", ss_cyc.size(), 2);
        if (ss_cyc.size() == 2) begin
            chk("wrap_addr0", ss_addr[0], 32'hFFFF_FF80);
            chk("wrap_addr1", ss_addr[1], 32'h0000_0000);
        end
        chk("wrap_sd_count", sd_cyc.size(), 1);

        // Abort during WAIT of row 1 of 4
        clear_logs();
        tick();
        n = cyc;
        start(32'h2000, 8'd4, 12'd8, 32'h40);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 18) begin
                chk("abort_pre_row_idx", row_idx, 1);
                cfg_abort = 1'b1;
            end
            if (k == 19) chk("abort_busy", busy, 0);
        end
        chk("abort_ss_count", ss_cyc.size(), 2);
        chk("abort_sd_count", sd_cyc.size(), 0);

        clear_logs();
        tick();
        n = cyc;
        start(32'h3000, 8'd1, 12'd5, 32'h0);
        repeat (20) tick();
        chk("restart_ss_count", ss_cyc.size(), 1);
        if (ss_cyc.size() == 1) begin
            chk("restart_ss_cyc", ss_cyc[0] - n, 1);
            chk("restart_addr", ss_addr[0], 32'h3000);
        end
        chk("restart_sd_count", sd_cyc.size(), 1);
        if (sd_cyc.size() == 1) chk("restart_sd_cyc", sd_cyc[0] - n, 12);

        // Back-to-back: second cfg_start in the FIN cycle
        clear_logs();
        tick();
        n = cyc;
        start(32'h4000, 8'd1, 12'd3, 32'h0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 12) begin
                chk("b2b_fin_pulse", sched_done, 1);
                start(32'h5000, 8'd1, 12'd7, 32'h0);
            end
        end
        chk("b2b_ss_count", ss_cyc.size(), 2);
        if (ss_cyc.size() == 2) begin
            chk("b2b_ss1_cyc", ss_cyc[1] - n, 13);
            chk("b2b_addr1", ss_addr[1], 32'h5000);
            chk("b2b_len1", ss_len[1], 7);
        end
        chk("b2b_sd_count", sd_cyc.size(), 2);
        if (sd_cyc.size() == 2) chk("b2b_sd1_cyc", sd_cyc[1] - n, 24);

        // Reset mid-WAIT
        clear_logs();
        tick();
        n = cyc;
        start(32'h6000, 8'd2, 12'd9, 32'h20);
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 4) chk("mid_rst_busy_pre", busy, 1);
            if (k == 5) rst = 1'b1;
            if (k == 6) begin
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_waddr", param_waddr, 0);
                chk("mid_rst_iolen", param_iolen, 0);
                chk("mid_rst_row_idx", row_idx, 0);
                chk("mid_rst_store_start", store_start, 0);
            end
        end
        chk("mid_rst_ss_count", ss_cyc.size(), 1);
        chk("mid_rst_sd_count", sd_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
